// File: rtl/demux1x4_stream_if.sv
// rtl/demux1x4_stream_if.sv - handshake bundle for demux1x4_stream; out_cnt exists only with DEMUX_CNT_EN
interface demux1x4_stream_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0]   in_data;
    logic [1:0]          in_sel;
    logic                in_valid;
    logic                in_ready;
    logic [4*DATA_W-1:0] out_data;
    logic [3:0]          out_valid;
    logic [3:0]          out_ready;
`ifdef DEMUX_CNT_EN
    logic [31:0]         out_cnt;
`endif

    // Upstream source plus the four sinks, seen from outside the demux.
    modport master (
        output in_data,
        output in_sel,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
`ifdef DEMUX_CNT_EN
        input  out_cnt,
`endif
        input  out_valid
    );

    // The demux itself.
    modport slave (
        input  in_data,
        input  in_sel,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
`ifdef DEMUX_CNT_EN
        output out_cnt,
`endif
        output out_valid
    );
endinterface

// File: rtl/demux1x4_stream.sv
// rtl/demux1x4_stream.sv - 1:4 stream demux with a 2-entry FIFO per channel; DEMUX_CNT_EN adds out_cnt
module demux1x4_stream #(
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    demux1x4_stream_if.slave bus
);
    // Channel state doubles as the occupancy count (0, 1 or 2 entries).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } ch_state_t;

    ch_state_t         state_q [4];
    ch_state_t         state_d [4];
    logic [3:0]        wptr_q;
    logic [3:0]        rptr_q;
    logic [DATA_W-1:0] mem0_q [4];
    logic [DATA_W-1:0] mem1_q [4];
    logic [3:0]        push;
    logic [3:0]        pop;
    logic              in_ready_w;

    // Ready depends only on the addressed channel having room; a sink popping
    // the same cycle does not open a slot early, keeping in_sel the only comb path.
    always_comb begin
        in_ready_w = (state_q[bus.in_sel] != FULL);
    end

    assign bus.in_ready = in_ready_w;

    // Per-channel push and pop strobes.
    always_comb begin
        push = '0;
        pop  = '0;
        for (int k = 0; k < 4; k++) begin
            push[k] = bus.in_valid && in_ready_w && (bus.in_sel == 2'(k));
            pop[k]  = (state_q[k] != EMPTY) && bus.out_ready[k];
        end
    end

    // Occupancy transitions; a push and pop together leave the count unchanged.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                EMPTY: begin
                    if (push[k]) begin
                        state_d[k] = HALF;
                    end
                end
                HALF: begin
                    if (push[k] && !pop[k]) begin
                        state_d[k] = FULL;
                    end else if (pop[k] && !push[k]) begin
                        state_d[k] = EMPTY;
                    end
                end
                FULL: begin
                    if (pop[k]) begin
                        state_d[k] = HALF;
                    end
                end
                default: begin
                    state_d[k] = EMPTY;
                end
            endcase
        end
    end

    // Channel state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= EMPTY;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
            end
        end
    end

    // FIFO storage and pointers; reset clears memories so out_data reads 0 afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int k = 0; k < 4; k++) begin
                mem0_q[k] <= '0;
                mem1_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (push[k]) begin
                    if (wptr_q[k]) begin
                        mem1_q[k] <= bus.in_data;
                    end else begin
                        mem0_q[k] <= bus.in_data;
                    end
                    wptr_q[k] <= ~wptr_q[k];
                end
                if (pop[k]) begin
                    rptr_q[k] <= ~rptr_q[k];
                end
            end
        end
    end

    // Head entry and valid per channel, selected purely from registered state.
    always_comb begin
        bus.out_data  = '0;
        bus.out_valid = '0;
        for (int k = 0; k < 4; k++) begin
            bus.out_data[k*DATA_W +: DATA_W] = rptr_q[k] ? mem1_q[k] : mem0_q[k];
            bus.out_valid[k]                 = (state_q[k] != EMPTY);
        end
    end

`ifdef DEMUX_CNT_EN
    logic [7:0] cnt_q [4];

    // Per-channel output handshake counters, wrapping at 8 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (pop[k]) begin
                    cnt_q[k] <= cnt_q[k] + 8'd1;
                end
            end
        end
    end

    // Pack the counters onto the out_cnt bus.
    always_comb begin
        bus.out_cnt = '0;
        for (int k = 0; k < 4; k++) begin
            bus.out_cnt[k*8 +: 8] = cnt_q[k];
        end
    end
`endif
endmodule

// File: tb/tb_demux1x4_stream.sv
// tb/tb_demux1x4_stream.sv - self-checking bench for demux1x4_stream
module tb_demux1x4_stream;
    localparam int DATA_W = 8;
    localparam int NVEC   = 22;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    demux1x4_stream_if #(.DATA_W(DATA_W)) bus ();

    demux1x4_stream #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] ordy;
        logic       exp_rdy;
        logic [3:0] exp_ov;
    } vec_t;

    vec_t       vecs [NVEC];
    logic [7:0] sbq [4][$];
    logic [7:0] cnt_model [4];
    int         checks = 0;
    int         errors = 0;
    logic       last_acc = 1'b0;
    logic [31:0] rnd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = r;
    endtask

    // One clock: compare against the scoreboard mid-cycle, then update it at the edge.
    task automatic cycle();
        logic       acc;
        logic [3:0] pops;
        logic       exp_rdy;
        logic [3:0] exp_ov;
        acc  = 1'b0;
        pops = '0;
        @(negedge clk);
        if (rst_n) begin
            exp_rdy = (sbq[bus.in_sel].size() < 2);
            for (int k = 0; k < 4; k++) begin
                exp_ov[k] = (sbq[k].size() != 0);
            end
            check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
            for (int k = 0; k < 4; k++) begin
                if (exp_ov[k]) begin
                    check("out_data", 32'(bus.out_data[k*8 +: 8]), 32'(sbq[k][0]));
                end
            end
            acc  = bus.in_valid & exp_rdy;
            pops = exp_ov & bus.out_ready;
        end
        @(posedge clk);
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                sbq[k].delete();
                cnt_model[k] = 8'd0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (pops[k]) begin
                    void'(sbq[k].pop_front());
                    cnt_model[k] = cnt_model[k] + 8'd1;
                end
            end
            if (acc) begin
                sbq[bus.in_sel].push_back(bus.in_data);
            end
        end
        last_acc = acc;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Routing, all sinks ready.
        vecs[0]  = '{1'b1, 2'd0, 8'h11, 4'hF, 1'b1, 4'b0000};
        vecs[1]  = '{1'b1, 2'd1, 8'h22, 4'hF, 1'b1, 4'b0001};
        vecs[2]  = '{1'b1, 2'd2, 8'h33, 4'hF, 1'b1, 4'b0010};
        vecs[3]  = '{1'b1, 2'd3, 8'h44, 4'hF, 1'b1, 4'b0100};
        vecs[4]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b1000};
        vecs[5]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000};
        // Backpressure on channel 2, channel 0 traffic passes meanwhile.
        vecs[6]  = '{1'b1, 2'd2, 8'hA0, 4'hB, 1'b1, 4'b0000};
        vecs[7]  = '{1'b1, 2'd2, 8'hA1, 4'hB, 1'b1, 4'b0100};
        vecs[8]  = '{1'b1, 2'd2, 8'hA2, 4'hB, 1'b0, 4'b0100};
        vecs[9]  = '{1'b1, 2'd0, 8'h55, 4'hB, 1'b1, 4'b0100};
        vecs[10] = '{1'b1, 2'd2, 8'hA2, 4'hB, 1'b0, 4'b0101};
        vecs[11] = '{1'b1, 2'd2, 8'hA2, 4'hF, 1'b0, 4'b0100};
        vecs[12] = '{1'b1, 2'd2, 8'hA2, 4'hF, 1'b1, 4'b0100};
        vecs[13] = '{1'b0, 2'd2, 8'h00, 4'hF, 1'b1, 4'b0100};
        vecs[14] = '{1'b0, 2'd2, 8'h00, 4'hF, 1'b1, 4'b0000};
        // Simultaneous push/pop on channel 1, then fill and drain.
        vecs[15] = '{1'b1, 2'd1, 8'h61, 4'h0, 1'b1, 4'b0000};
        vecs[16] = '{1'b1, 2'd1, 8'h62, 4'h2, 1'b1, 4'b0010};
        vecs[17] = '{1'b1, 2'd1, 8'h63, 4'h0, 1'b1, 4'b0010};
        vecs[18] = '{1'b0, 2'd1, 8'h00, 4'h0, 1'b0, 4'b0010};
        vecs[19] = '{1'b0, 2'd1, 8'h00, 4'h2, 1'b0, 4'b0010};
        vecs[20] = '{1'b0, 2'd1, 8'h00, 4'h2, 1'b1, 4'b0010};
        vecs[21] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000};

        for (int k = 0; k < 4; k++) begin
            cnt_model[k] = 8'd0;
        end

        // Reset for two cycles with random inputs.
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rnd = $urandom;
            drive(rnd[0], rnd[2:1], rnd[10:3], rnd[14:11]);
            cycle();
        end
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        check("rst_out_data", 32'(bus.out_data), 32'h0);
`ifdef DEMUX_CNT_EN
        check("rst_out_cnt", bus.out_cnt, 32'h0);
`endif

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].v, vecs[i].sel, vecs[i].data, vecs[i].ordy);
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_rdy));
            check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
            cycle();
        end

        // Reset while channel 3 is full.
        drive(1'b1, 2'd3, 8'h71, 4'h0);
        cycle();
        drive(1'b1, 2'd3, 8'h72, 4'h0);
        cycle();
        drive(1'b0, 2'd3, 8'h00, 4'h0);
        #1;
        check("ch3_full_in_ready", 32'(bus.in_ready), 32'h0);
        check("ch3_full_out_valid", 32'(bus.out_valid[3]), 32'h1);
        rst_n = 1'b0;
        drive(1'b1, 2'd3, 8'h7F, 4'hF);
        cycle();
        rst_n = 1'b1;
        drive(1'b1, 2'd3, 8'h73, 4'h0);
        #1;
        check("midrst_out_valid3", 32'(bus.out_valid[3]), 32'h0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'h1);
        cycle();
        drive(1'b0, 2'd3, 8'h00, 4'h8);
        #1;
        check("midrst_new_beat_valid", 32'(bus.out_valid), 32'h8);
        check("midrst_new_beat_data", 32'(bus.out_data[31:24]), 32'h73);
        cycle();

        // Fresh reset, then 257 beats streamed through channel 0 at full rate.
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, 2'd0, 8'(i), 4'hF);
            cycle();
        end
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        cycle();
        cycle();
        check("stream_drained", 32'(bus.out_valid), 32'h0);
`ifdef DEMUX_CNT_EN
        check("cnt_wrap", bus.out_cnt, 32'h0000_0001);
`endif

        // Random traffic; stalled beats are held until accepted.
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom;
            if (last_acc || !bus.in_valid) begin
                drive(rnd[0], rnd[2:1], rnd[10:3], rnd[14:11]);
            end else begin
                bus.out_ready = rnd[14:11];
            end
            cycle();
        end
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        for (int i = 0; i < 3; i++) begin
            cycle();
        end
        check("final_drain", 32'(bus.out_valid), 32'h0);
`ifdef DEMUX_CNT_EN
        check("final_cnt", bus.out_cnt,
              {cnt_model[3], cnt_model[2], cnt_model[1], cnt_model[0]});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux1x4_stream.md
# demux1x4_stream

Stream demultiplexer that routes each accepted input beat to one of four output channels, chosen by a 2-bit select. It is the distribution counterpart of the team's 4:1 mux: one producer fans out to four consumers. Each output channel has a 2-entry FIFO, so a stalled consumer blocks only beats addressed to that channel. The block sits between a single upstream source and four independent downstream sinks, all in one clock domain.

## Interface

**Parameters**
- `DATA_W`, default 8: width of one data beat.

**Ports**
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: reset. Synchronous, active-low.
- `in_data`, input, `DATA_W`: input beat.
- `in_sel`, input, 2: destination channel 0–3. Sampled together with `in_data`.
- `in_valid`, input, 1: input beat present.
- `in_ready`, output, 1: block can accept the beat addressed by the current `in_sel`.
- `out_data`, output, `4*DATA_W`: head entry of each channel. Channel k occupies bits `[k*DATA_W +: DATA_W]`.
- `out_valid`, output, 4: channel k FIFO is non-empty.
- `out_ready`, input, 4: sink k accepts its head entry.
- `out_cnt`, output, 32: present only with `DEMUX_CNT_EN`. Four 8-bit per-channel counts; channel k occupies bits `[k*8 +: 8]`.

## Operation

- **Per-channel state.** Each channel k has a 2-entry FIFO (`mem0`, `mem1`), a 1-bit read pointer, a 1-bit write pointer, and an occupancy counter `occ[k]` in the range 0..2.
  - Channel state is EMPTY (`occ=0`), HALF (`occ=1`) or FULL (`occ=2`).
- **Input ready.** `in_ready = (occ[in_sel] != 2)`. This is combinational on `in_sel` and state only; it does not depend on `in_valid` and there is no bypass from `out_ready`.
- **Push.** When `in_valid & in_ready`, write `in_data` at `wptr[in_sel]`, toggle that pointer, and increment `occ`.
- **Pop.** When `out_valid[k] & out_ready[k]`, toggle `rptr[k]` and decrement `occ`.
- **Simultaneous push and pop on the same channel.** `occ` is unchanged and both pointers advance.
  - In FULL, a push cannot occur that cycle, because `in_ready` was already 0.
- **Output valid.** `out_valid[k] = (occ[k] != 0)`.
- **Output data.** `out_data` channel k = `mem[rptr[k]]`. It holds a stale value while empty, and its value is don't-care when `out_valid[k]=0`.
- **Channel independence.** Pops on different channels in the same cycle are independent. A full channel never blocks beats addressed to other channels.
- **Upstream contract.** `in_data` and `in_sel` must be held stable while `in_valid=1` and `in_ready=0`.
  - If `in_sel` changes while stalled, that is legal, but `in_ready` re-evaluates for the new channel.
- **State transitions (per channel).**
  - EMPTY: push → HALF.
  - HALF: push only → FULL; pop only → EMPTY; push and pop → HALF.
  - FULL: pop → HALF.

## Timing

- **Reset** (`rst_n=0` sampled on a rising edge):
  - `occ`, pointers, memories and `out_cnt` are cleared to 0.
  - After reset, `out_valid=4'b0000`, `out_data=0`, and `in_ready=1`.
  - Reset mid-operation discards all buffered beats. Handshakes in the reset cycle are ignored.
- **Latency.** A beat accepted at edge N gives `out_valid[k]=1` with that data in the cycle after edge N, i.e. 1 cycle.
- **Throughput.** One beat per cycle in, and one beat per cycle per channel out. Sustained streaming to one channel with `out_ready=1` runs at full rate, holding `occ=1`.
- **Combinational paths.** All outputs except `in_ready` are register-driven. `in_ready` has a combinational path from `in_sel` only.

## Configuration

- **`DEMUX_CNT_EN` defined:** the `out_cnt` port exists.
  - Each 8-bit count increments on every output handshake of its channel (`out_valid[k] & out_ready[k]`).
  - It wraps from 255 to 0 and is cleared by reset.
- **`DEMUX_CNT_EN` undefined:** the `out_cnt` port and its counters are absent. All other behaviour is identical.

## Test plan

- **Reset.** Drive `rst_n=0` for 2 cycles with random inputs → `out_valid=0`, `in_ready=1`, `out_cnt=0`.
- **Routing.** Send beats 0x11, 0x22, 0x33, 0x44 with `in_sel`=0,1,2,3 and all `out_ready=1`.
  - Required: each `out_valid[k]` pulses exactly 1 cycle after its accept, carrying the matching byte on its channel slice.
- **Backpressure.** Hold `out_ready[2]=0` and send 3 beats to channel 2: 0xA0, 0xA1, 0xA2.
  - Required: `in_ready` falls after 2 accepts.
  - Required: a beat sent to channel 0 meanwhile is accepted and delivered.
  - Then raise `out_ready[2]` → 0xA0, 0xA1, 0xA2 drain in order.
- **Simultaneous push/pop.** With channel 1 HALF, push and pop channel 1 in the same cycle → `occ` stays 1 and the data order is preserved.
- **Reset mid-traffic.** With channel 3 FULL, assert `rst_n=0` for 1 cycle → `out_valid[3]=0`, and the next beat to channel 3 is accepted immediately.
- **Counter wrap** (`DEMUX_CNT_EN`). Stream 257 beats through channel 0 → `out_cnt[7:0]=1`, other counts 0.
